// File: rtl/lstm_seq_controller.sv
// Sequences one shared LSTM cell over the characters of a word, then takes an
// argmax over the final prediction vector using IEEE-754 sign/magnitude ordering.
module lstm_seq_controller #(
  parameter int SEQ_LENGTH = 4,
  parameter int ENC        = 27,
  parameter int HIDDEN     = 25,
  parameter int BW         = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ENC*SEQ_LENGTH-1:0] word,
  output logic                   step_valid,
  input  logic                   step_ack,
  output logic [ENC-1:0]         char_out,
  output logic [BW*HIDDEN-1:0]   hidden_out,
  output logic [BW*HIDDEN-1:0]   cell_out,
  input  logic [BW*HIDDEN-1:0]   hidden_upd,
  input  logic [BW*HIDDEN-1:0]   cell_upd,
  input  logic [BW*ENC-1:0]      pred_in,
  output logic                   busy,
  output logic                   done,
  output logic [BW*ENC-1:0]      pred,
  output logic [5:0]             predicted_char
);

  localparam int TW = (SEQ_LENGTH > 1) ? $clog2(SEQ_LENGTH) : 1;
  localparam int KW = (ENC > 1) ? $clog2(ENC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(SEQ_LENGTH - 1);
  localparam logic [KW-1:0] K_LAST = KW'(ENC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ARGMAX, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [ENC*SEQ_LENGTH-1:0] word_q, word_d;
  logic [TW-1:0]             t_q, t_d, t_nxt;
  logic [KW-1:0]             k_q, k_d, best_idx;
  logic [BW-1:0]             max_val_q, max_val_d, cand;
  logic [KW-1:0]             max_idx_q, max_idx_d;
  logic                      step_valid_q, step_valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [ENC-1:0]            char_out_q, char_out_d;
  logic [BW*HIDDEN-1:0]      hidden_q, hidden_d;
  logic [BW*HIDDEN-1:0]      cell_q, cell_d;
  logic [BW*ENC-1:0]         pred_q, pred_d;
  logic [5:0]                pchar_q, pchar_d;
  logic                      cand_gt;

  // Strict a > m on raw float bits; +0/-0 compare equal, NaN follows the bit rule.
  function automatic logic fp_gt(input logic [BW-1:0] a, input logic [BW-1:0] m);
    logic r;
    if (a[BW-2:0] == '0 && m[BW-2:0] == '0) r = 1'b0;
    else if (a[BW-1] != m[BW-1])            r = ~a[BW-1];
    else if (!a[BW-1])                      r = (a[BW-2:0] > m[BW-2:0]);
    else                                    r = (a[BW-2:0] < m[BW-2:0]);
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    t_d          = t_q;
    k_d          = k_q;
    max_val_d    = max_val_q;
    max_idx_d    = max_idx_q;
    step_valid_d = step_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    char_out_d   = char_out_q;
    hidden_d     = hidden_q;
    cell_d       = cell_q;
    pred_d       = pred_q;
    pchar_d      = pchar_q;
    t_nxt        = t_q + 1'b1;
    cand         = pred_q[int'(k_q)*BW +: BW];
    cand_gt      = fp_gt(cand, max_val_q);
    best_idx     = cand_gt ? k_q : max_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_d       = word;
          hidden_d     = '0;
          cell_d       = '0;
          t_d          = '0;
          char_out_d   = word[0 +: ENC];
          step_valid_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        if (step_ack) begin
          hidden_d = hidden_upd;
          cell_d   = cell_upd;
          pred_d   = pred_in;
          if (t_q != T_LAST) begin
            t_d        = t_nxt;
            char_out_d = word_q[int'(t_nxt)*ENC +: ENC];
          end else begin
            step_valid_d = 1'b0;
            max_val_d    = pred_in[0 +: BW];
            max_idx_d    = '0;
            k_d          = KW'(1);
            state_d      = S_ARGMAX;
          end
        end
      end
      S_ARGMAX: begin
        if (cand_gt) begin
          max_val_d = cand;
          max_idx_d = k_q;
        end
        // The last element's result goes straight to predicted_char so it is visible with done.
        if (k_q == K_LAST) begin
          pchar_d = 6'(best_idx);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      t_q          <= '0;
      k_q          <= '0;
      max_val_q    <= '0;
      max_idx_q    <= '0;
      step_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      char_out_q   <= '0;
      hidden_q     <= '0;
      cell_q       <= '0;
      pred_q       <= '0;
      pchar_q      <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      t_q          <= t_d;
      k_q          <= k_d;
      max_val_q    <= max_val_d;
      max_idx_q    <= max_idx_d;
      step_valid_q <= step_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      char_out_q   <= char_out_d;
      hidden_q     <= hidden_d;
      cell_q       <= cell_d;
      pred_q       <= pred_d;
      pchar_q      <= pchar_d;
    end
  end

  assign step_valid     = step_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign char_out       = char_out_q;
  assign hidden_out     = hidden_q;
  assign cell_out       = cell_q;
  assign pred           = pred_q;
  assign predicted_char = pchar_q;

endmodule

// File: tb/tb_lstm_seq_controller.sv
// Bench for lstm_seq_controller: directed words, a behavioural cell with configurable
// ack delay, and a scoreboard monitor checking every step and every done pulse.
module tb_lstm_seq_controller;
  localparam int SEQ = 4;
  localparam int ENC = 27;
  localparam int HID = 25;
  localparam int BW  = 32;
  localparam int WW  = ENC * SEQ;

  logic              clk = 1'b0;
  logic              rst_n, start, step_valid, step_ack, busy, done;
  logic [WW-1:0]     word_in;
  logic [ENC-1:0]    char_out;
  logic [BW*HID-1:0] hidden_out, cell_out, hidden_upd, cell_upd, exp_h, exp_c;
  logic [BW*ENC-1:0] pred_in, pred, pv_a, pv_b, pv_c;
  logic [5:0]        predicted_char;

  typedef struct {logic [ENC-1:0] ch; int s;} step_t;
  typedef struct {logic [5:0] ch; int edge_n; logic [BW*ENC-1:0] pv;} done_t;
  step_t exp_step_q[$];
  done_t exp_done_q[$];
  step_t mon_step;
  done_t mon_done;

  int checks = 0, errors = 0, edge_cnt = 0;
  int step_no = 0, ack_delay = 0, wait_cnt = 0;

  lstm_seq_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word(word_in),
    .step_valid(step_valid), .step_ack(step_ack), .char_out(char_out),
    .hidden_out(hidden_out), .cell_out(cell_out),
    .hidden_upd(hidden_upd), .cell_upd(cell_upd), .pred_in(pred_in),
    .busy(busy), .done(done), .pred(pred), .predicted_char(predicted_char)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [BW*HID-1:0] hid(input int s);
    logic [31:0] v;
    v = 32'h4100_0000 + 32'(s);
    return {HID{v}};
  endfunction

  function automatic logic [BW*HID-1:0] cel(input int s);
    logic [31:0] v;
    v = 32'hC100_0000 + 32'(s);
    return {HID{v}};
  endfunction

  function automatic logic [WW-1:0] mk_word(input int c0, input int c1, input int c2, input int c3);
    logic [WW-1:0] w;
    w = '0;
    w[c0] = 1'b1;
    w[ENC + c1] = 1'b1;
    w[2*ENC + c2] = 1'b1;
    w[3*ENC + c3] = 1'b1;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < 32; i++) begin
        if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
          $display("FAIL %s: word %0d got %h expected %h", nm, i, act[i*32 +: 32], exp[i*32 +: 32]);
          break;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input int e);
    while (edge_cnt < e) tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 1024'(busy), 1024'(0));
    chk({tag, "_done"}, 1024'(done), 1024'(0));
    chk({tag, "_step_valid"}, 1024'(step_valid), 1024'(0));
    chk({tag, "_char_out"}, 1024'(char_out), 1024'(0));
    chk({tag, "_hidden_out"}, 1024'(hidden_out), 1024'(0));
    chk({tag, "_cell_out"}, 1024'(cell_out), 1024'(0));
    chk({tag, "_pred"}, 1024'(pred), 1024'(0));
    chk({tag, "_predicted_char"}, 1024'(predicted_char), 1024'(0));
  endtask

  // Behavioural cell: acks after ack_delay waiting cycles, updates tagged by step number.
  initial begin
    step_ack   = 1'b0;
    hidden_upd = '0;
    cell_upd   = '0;
    forever begin
      tick();
      if (step_ack) step_no++;
      hidden_upd = hid(step_no + 1);
      cell_upd   = cel(step_no + 1);
      if (step_valid) begin
        if (wait_cnt >= ack_delay) begin
          step_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          step_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        step_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Driver: issue one word, push expectations, optionally inject ignored starts or a reset.
  task automatic run_word(input logic [WW-1:0] w, input int dly, input logic [BW*ENC-1:0] pv,
                          input logic [5:0] exp_ch, input bit extra_starts, input int rst_at);
    int s_edge;
    int done_edge;
    done_t d;
    ack_delay = dly;
    pred_in   = pv;
    word_in   = w;
    start     = 1'b1;
    step_no   = 0;
    s_edge    = edge_cnt + 1;
    done_edge = s_edge + 30 + 4*dly;
    for (int t = 0; t < SEQ; t++) exp_step_q.push_back('{ch: w[t*ENC +: ENC], s: t});
    d.ch = exp_ch; d.edge_n = done_edge; d.pv = pv;
    exp_done_q.push_back(d);
    tick();
    start   = 1'b0;
    word_in = ~w;
    chk("busy_after_start", 1024'(busy), 1024'(1));
    if (rst_at > 0) begin
      wait_edge(s_edge + rst_at - 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_step_q.delete();
      exp_done_q.delete();
      check_zero("midrun_reset");
      repeat (40) tick();
      chk("idle_after_abort_busy", 1024'(busy), 1024'(0));
      return;
    end
    if (extra_starts) begin
      tick();
      start   = 1'b1;
      word_in = mk_word(1, 1, 1, 1);
      tick();
      start = 1'b0;
      wait_edge(done_edge);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 300 && exp_done_q.size() != 0; i++) tick();
    if (exp_done_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done pulse within 300 cycles, expected one");
      exp_done_q.delete();
      exp_step_q.delete();
    end
    tick();
    chk("idle_busy", 1024'(busy), 1024'(0));
    chk("idle_step_valid", 1024'(step_valid), 1024'(0));
    repeat (2) tick();
  endtask

  // Monitor/scoreboard: every presented step and every done pulse is checked against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (step_valid) begin
        if (exp_step_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: step_valid=1 expected 0");
        end else begin
          mon_step = exp_step_q[0];
          exp_h = (mon_step.s == 0) ? '0 : hid(mon_step.s);
          exp_c = (mon_step.s == 0) ? '0 : cel(mon_step.s);
          chk("step_char_out", 1024'(char_out), 1024'(mon_step.ch));
          chk("step_hidden_out", 1024'(hidden_out), 1024'(exp_h));
          chk("step_cell_out", 1024'(cell_out), 1024'(exp_c));
          if (step_ack) void'(exp_step_q.pop_front());
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 expected 0");
        end else begin
          mon_done = exp_done_q.pop_front();
          chk("done_predicted_char", 1024'(predicted_char), 1024'(mon_done.ch));
          chk("done_cycle", 1024'(edge_cnt), 1024'(mon_done.edge_n));
          chk("done_pred", 1024'(pred), 1024'(mon_done.pv));
          chk("done_busy_low", 1024'(busy), 1024'(0));
          chk("done_steps_consumed", 1024'(exp_step_q.size()), 1024'(0));
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    word_in = '0;
    pred_in = '0;
    pv_a = {ENC{32'h3F80_0000}};
    pv_a[12*BW +: BW] = 32'h40A0_0000;
    pv_b = {ENC{32'hBF80_0000}};
    pv_b[4*BW +: BW]  = 32'hBF00_0000;
    pv_b[20*BW +: BW] = 32'hBF00_0000;
    pv_c = {ENC{32'hBF80_0000}};
    pv_c[0 +: BW]  = 32'h8000_0000;
    pv_c[BW +: BW] = 32'h0000_0000;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    run_word(mk_word(3, 5, 7, 9), 0, pv_a, 6'd12, 1'b1, 0);
    run_word(mk_word(3, 5, 7, 9), 3, pv_a, 6'd12, 1'b0, 0);
    run_word(mk_word(0, 1, 2, 26), 0, pv_b, 6'd4, 1'b0, 0);
    run_word(mk_word(26, 13, 8, 4), 0, pv_c, 6'd0, 1'b0, 0);
    run_word(mk_word(2, 4, 6, 8), 3, pv_b, 6'd4, 1'b0, 10);
    run_word(mk_word(10, 11, 12, 13), 0, pv_a, 6'd12, 1'b0, 0);

    rst_n   = 1'b0;
    start   = 1'b1;
    word_in = mk_word(1, 2, 3, 4);
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    chk("start_in_reset_busy", 1024'(busy), 1024'(0));
    tick();
    chk("start_in_reset_step_valid", 1024'(step_valid), 1024'(0));
    chk("start_in_reset_busy2", 1024'(busy), 1024'(0));
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
